// File: rtl/column_height_tracker.sv
// Per-column fill tracker for a COLS x ROWS Connect4 board with landing row and move count.
// Define CHT_UNDO_EN to compile in the move-history stack and last-move undo.
module column_height_tracker #(
    parameter int COLS = 7,
    parameter int ROWS = 6,
    parameter int CW   = $clog2(COLS),
    parameter int HW   = $clog2(ROWS + 1),
    parameter int MW   = $clog2(COLS * ROWS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CW-1:0]        col,
    input  logic                 add,
    input  logic                 undo,
    output logic [COLS*HW-1:0]   heights,
    output logic [COLS-1:0]      col_full,
    output logic                 board_full,
    output logic [MW-1:0]        move_count,
    output logic                 accept,
    output logic                 reject,
    output logic [CW-1:0]        last_col,
    output logic [HW-1:0]        last_row
);

    localparam int DEPTH = COLS * ROWS;
    localparam logic [HW-1:0] FULL = HW'(ROWS);

    logic [HW-1:0] h   [COLS];
    logic [HW-1:0] h_n [COLS];
    logic [COLS-1:0] cf_n;
    logic [MW-1:0] mc_n;
    logic [CW-1:0] lc_n;
    logic [HW-1:0] lr_n;
    logic acc_n, rej_n;
    logic undo_req, push, pop, col_ok;
    logic [CW-1:0] pop_col;
    logic [HW-1:0] add_h, pop_h;

`ifdef CHT_UNDO_EN
    // Stack pointer is move_count itself: top entry lives at move_count-1.
    logic [CW-1:0] stack [DEPTH];

    assign undo_req = undo;
    assign pop_col  = stack[move_count - 1'b1];

    always_ff @(posedge clk) begin
        if (push)
            stack[move_count] <= col;
    end
`else
    logic unused_undo;

    assign unused_undo = undo;
    assign undo_req    = 1'b0;
    assign pop_col     = '0;
`endif

    always_comb begin
        col_ok = {1'b0, col} < (CW + 1)'(COLS);
        add_h  = '0;
        pop_h  = '0;
        for (int c = 0; c < COLS; c++) begin
            if (CW'(c) == col)
                add_h = h[c];
            if (CW'(c) == pop_col)
                pop_h = h[c];
        end
    end

    always_comb begin
        mc_n  = move_count;
        lc_n  = last_col;
        lr_n  = last_row;
        acc_n = 1'b0;
        rej_n = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        if (add && undo_req) begin
            rej_n = 1'b1;
        end else if (add) begin
            if (!col_ok || add_h == FULL) begin
                rej_n = 1'b1;
            end else begin
                push  = 1'b1;
                acc_n = 1'b1;
                lc_n  = col;
                lr_n  = add_h;
                mc_n  = move_count + 1'b1;
            end
        end else if (undo_req) begin
            if (move_count == '0) begin
                rej_n = 1'b1;
            end else begin
                pop   = 1'b1;
                acc_n = 1'b1;
                lc_n  = pop_col;
                lr_n  = pop_h - 1'b1;
                mc_n  = move_count - 1'b1;
            end
        end
        // Flags come from next-state heights so they track heights cycle for cycle.
        for (int c = 0; c < COLS; c++) begin
            h_n[c] = h[c];
            if (push && CW'(c) == col)
                h_n[c] = h[c] + 1'b1;
            else if (pop && CW'(c) == pop_col)
                h_n[c] = h[c] - 1'b1;
            cf_n[c] = (h_n[c] == FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < COLS; c++)
                h[c] <= '0;
            col_full   <= '0;
            board_full <= 1'b0;
            move_count <= '0;
            accept     <= 1'b0;
            reject     <= 1'b0;
            last_col   <= '0;
            last_row   <= '0;
        end else begin
            h          <= h_n;
            col_full   <= cf_n;
            board_full <= &cf_n;
            move_count <= mc_n;
            accept     <= acc_n;
            reject     <= rej_n;
            last_col   <= lc_n;
            last_row   <= lr_n;
        end
    end

    for (genvar g = 0; g < COLS; g++) begin : g_pack
        assign heights[g*HW +: HW] = h[g];
    end

endmodule

// File: doc/column_height_tracker.md
# column_height_tracker

Parametrised per-column fill tracker for the Connect4 board. It generalises the fixed four-channel, 3-bit column counter to COLS columns of ROWS cells. Each add request is checked against column range and fullness, then accepted or rejected with a one-cycle pulse. The block reports the landing row, per-column and board-full flags, a move count and, optionally, last-move undo. It sits between the player input/turn controller and the board state/win-check logic.

## Interface
- COLS, 7, number of board columns (2..16)
- ROWS, 6, number of cells per column (1..15)
- CW, $clog2(COLS), column index width (derived, do not override)
- HW, $clog2(ROWS+1), height field width (derived)
- MW, $clog2(COLS*ROWS+1), move count width (derived)

- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- col  input  CW  column selected for add
- add  input  1  request to drop a piece into col; sampled every edge, one request per high cycle
- undo  input  1  request to remove the most recent accepted piece
- heights  output  COLS*HW  packed heights; column c occupies bits [c*HW +: HW]
- col_full  output  COLS  bit c high when height c == ROWS
- board_full  output  1  high when every column is full
- move_count  output  MW  number of pieces currently on the board
- accept  output  1  one-cycle pulse: previous cycle's request was executed
- reject  output  1  one-cycle pulse: previous cycle's request was refused, no state change
- last_col  output  CW  column of the last executed add or undo
- last_row  output  HW  for add, the row filled (0 = bottom); for undo, the row vacated

## Operation
- Reset values: heights, col_full, board_full, move_count, accept, reject, last_col and last_row are all 0. The history stack is emptied.
- All outputs are registered. col_full and board_full are registered copies derived from the next-state heights, so they are consistent with heights in the same cycle.
- add alone:
  - col >= COLS -> reject.
  - height[col] == ROWS -> reject; the height stays at ROWS and never wraps.
  - Otherwise: last_row <= height[col], height[col] +1, move_count +1, last_col <= col, accept. The column is pushed to the history stack.
- undo alone (UNDO_EN): stack empty -> reject. Otherwise pop column c, height[c] -1, move_count -1, last_col <= c, last_row <= new height[c], accept.
- add and undo in the same cycle -> reject; nothing changes.
- Neither add nor undo asserted -> accept = reject = 0; state holds.
- accept and reject are never high together.
- Arithmetic: heights are unsigned HW bits and saturate; they can never exceed ROWS or go below 0. move_count always equals the sum of heights.

## Timing
- Request sampled at edge N; heights, flags, last_* and the accept/reject pulse are all visible after edge N (latency 1). The pulse lasts exactly one cycle.
- add may be held high for back-to-back requests, one per cycle. Each cycle is evaluated against the state updated by the previous cycle.
- reset has priority over add and undo. Asserting reset mid-sequence clears everything at that edge, and any request in the same cycle is dropped with no pulse.
- No internal multi-cycle state. The history stack is COLS*ROWS entries of CW bits, with its pointer equal to move_count.

## Configuration
- CHT_UNDO_EN defined: the history stack, undo handling and undo rejects are compiled in.
- CHT_UNDO_EN undefined: no stack is instantiated and the undo input is ignored. undo never causes accept or reject, and add && undo is treated as a plain add. All other behaviour is identical.

## Test plan
- After reset, COLS=7, ROWS=6: add col=3 on 6 consecutive cycles -> six accept pulses, last_row 0..5, height[3]=6, col_full=7'b0001000. A seventh add -> reject, height stays 6, move_count=6.
- add col=7 (out of range, COLS=7) -> reject, all heights 0, move_count 0.
- Fill all 42 cells, one per cycle in column-major order -> board_full rises in the cycle after the 42nd add, move_count=42. Any further add -> reject.
- CHT_UNDO_EN: add cols 2, 5, 5, then undo, undo -> accepts with last_col/last_row 5/1 then 5/0. height[5]=0, height[2]=1, move_count=1. Two more undos -> accept (2/0) then reject.
- add and undo high together -> reject, no state change. Without CHT_UNDO_EN the same stimulus -> accept as a plain add.
- Reset asserted while add=1 after 3 moves -> at the next edge all outputs are 0 with no pulse. add col=0 on the following cycle -> accept, last_row=0.
